// File: rtl/niosii_rom_pkg.sv
// Shared constants and types for the Nios II program-memory arbiter.
package niosii_rom_pkg;

  localparam int DEPTH = 2560;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int CW    = 16;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  localparam int REQ_IMEM = 0;
  localparam int REQ_DMEM = 1;

  // Read in flight: returns on the cycle after its grant.
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } rd_pend_t;

endpackage

// File: rtl/niosii_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module niosii_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|gnt) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/niosii_rom_arbiter.sv
// Shares the single-port program memory between the instruction master (m0)
// and the data/debug master (m1): arbitration, range check, write protection.
module niosii_rom_arbiter #(
  parameter int              DEPTH    = niosii_rom_pkg::DEPTH,
  parameter int              AW       = niosii_rom_pkg::AW,
  parameter int              DW       = niosii_rom_pkg::DW,
  parameter logic [DW-1:0]   ERR_DATA = DW'(niosii_rom_pkg::ERR_DATA),
  parameter int              CW       = niosii_rom_pkg::CW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              m0_read,
  input  logic [AW-1:0]     m0_address,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byteenable,
  input  logic [DW-1:0]     m1_writedata,
  input  logic              m1_debugaccess,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,
  output logic [AW-1:0]     mem_address,
  output logic [DW/8-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DW-1:0]     mem_writedata,
  output logic              mem_debugaccess,
  output logic              mem_clken,
  input  logic [DW-1:0]     mem_readdata,
  output logic [CW-1:0]     oor_count,
  output logic [CW-1:0]     wprot_count
);

  import niosii_rom_pkg::*;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_enable;
  logic          w_sel1;
  logic          w_any_gnt;
  logic [AW-1:0] w_addr;
  logic          w_oor;
  logic          w_is_write;
  logic          w_wprot;
  logic          w_issue;
  logic [DW-1:0] w_rdata;

  rd_pend_t      r_pend;
  logic [CW-1:0] r_oor_cnt;
  logic [CW-1:0] r_wprot_cnt;

  // Read and write together from m1 is treated as a write.
  assign w_req[REQ_IMEM] = m0_read;
  assign w_req[REQ_DMEM] = m1_read | m1_write;
  assign w_enable        = ~freeze & reset_n;

  niosii_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (reset_n),
    .req    (w_req),
    .enable (w_enable),
    .gnt    (w_gnt)
  );

  assign w_sel1     = w_gnt[REQ_DMEM];
  assign w_any_gnt  = |w_gnt;
  assign w_addr     = w_sel1 ? m1_address : m0_address;
  assign w_oor      = w_any_gnt & ({1'b0, w_addr} >= LP_DEPTH);
  assign w_is_write = w_sel1 & m1_write;
  // Out-of-range takes precedence: such writes count only as out-of-range.
  assign w_wprot    = w_is_write & ~w_oor & ~m1_debugaccess;
  assign w_issue    = w_any_gnt & ~w_oor & ~w_wprot;

  assign m0_waitrequest = w_req[REQ_IMEM] & ~w_gnt[REQ_IMEM];
  assign m1_waitrequest = w_req[REQ_DMEM] & ~w_gnt[REQ_DMEM];

  assign mem_address     = w_addr;
  assign mem_byteenable  = w_sel1 ? m1_byteenable : '1;
  assign mem_writedata   = w_sel1 ? m1_writedata : '0;
  assign mem_debugaccess = w_sel1 & m1_debugaccess;
  assign mem_chipselect  = w_issue;
  assign mem_write       = w_issue & w_is_write;
  assign mem_clken       = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend      <= '0;
      r_oor_cnt   <= '0;
      r_wprot_cnt <= '0;
    end else begin
      r_pend.valid <= w_any_gnt & ~w_is_write;
      r_pend.owner <= w_sel1;
      r_pend.err   <= w_oor;
      if (w_oor && !(&r_oor_cnt)) begin
        r_oor_cnt <= r_oor_cnt + CW'(1);
      end
      if (w_wprot && !(&r_wprot_cnt)) begin
        r_wprot_cnt <= r_wprot_cnt + CW'(1);
      end
    end
  end

  // Memory data arriving now belongs to the read granted last cycle.
  assign w_rdata          = r_pend.err ? ERR_DATA : mem_readdata;
  assign m0_readdatavalid = r_pend.valid & ~r_pend.owner;
  assign m1_readdatavalid = r_pend.valid & r_pend.owner;
  assign m0_readdata      = m0_readdatavalid ? w_rdata : '0;
  assign m1_readdata      = m1_readdatavalid ? w_rdata : '0;

  assign oor_count   = r_oor_cnt;
  assign wprot_count = r_wprot_cnt;

endmodule

// File: doc/niosii_rom_arbiter.md
Name: niosii_rom_arbiter

Overview:
- Shares the single-port on-chip program memory (2560 x 32, 12-bit word address, 1-cycle read latency, byte-enabled writes gated by debugaccess) between two Avalon-MM requesters.
- Requester 0 is the Nios II instruction master (read-only). Requester 1 is the data/debug master (read/write).
- Sits between the interconnect and the memory. Owns arbitration, read-data return routing, range checking and write protection.

Parameters:
- DEPTH, 2560, number of implemented 32-bit words; addresses >= DEPTH are out of range.
- AW, 12, word-address width.
- DW, 32, data width; byteenable width is DW/8.
- ERR_DATA, 32'hDEADBEEF, read data returned for out-of-range reads.
- CW, 16, width of the saturating error counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- freeze  in  1  when high, no new grants are issued.
- m0_read  in  1  instruction-master read request.
- m0_address  in  AW  instruction-master word address.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DW  read data to the instruction master.
- m0_readdatavalid  out  1  m0_readdata is valid.
- m1_read  in  1  data-master read request.
- m1_write  in  1  data-master write request.
- m1_address  in  AW  data-master word address.
- m1_byteenable  in  DW/8  data-master byte enables.
- m1_writedata  in  DW  data-master write data.
- m1_debugaccess  in  1  write-permission qualifier.
- m1_waitrequest  out  1  request not accepted this cycle.
- m1_readdata  out  DW  read data to the data master.
- m1_readdatavalid  out  1  m1_readdata is valid.
- mem_address  out  AW  to memory.
- mem_byteenable  out  DW/8  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  DW  to memory.
- mem_debugaccess  out  1  to memory.
- mem_clken  out  1  to memory; tied high.
- mem_readdata  in  DW  from memory; valid 1 cycle after the read is issued.
- oor_count  out  CW  number of out-of-range accesses.
- wprot_count  out  CW  number of writes dropped for missing debugaccess.

Behaviour:
- Reset values (async on reset_n low):
  - last_grant = 1, so m0 wins the first tie.
  - Pending-read valid flag = 0; owner tag = 0; error-read flag = 0.
  - Both counters = 0.
  - All readdatavalid outputs = 0; readdata outputs = 0.
  - mem_chipselect = 0 and mem_write = 0 (combinational from the grant, which is 0 during reset).
- Request definitions: req0 = m0_read. req1 = m1_read | m1_write. m1_read and m1_write both high is illegal and is treated as a write.
- Arbitration:
  - The decision is combinational in the same cycle.
  - When both requesters are present, the one not equal to last_grant wins (round-robin).
  - A single requester wins immediately.
  - No grant while freeze = 1 or reset_n = 0.
- last_grant updates on every grant, at the clock edge.
- m0_waitrequest = req0 & ~grant0; m1_waitrequest = req1 & ~grant1. A granted request completes in the grant cycle (Avalon accept).
- Memory drive: on grant, mem_address, byteenable, writedata and debugaccess are muxed from the winner. m0 drives byteenable = all ones and debugaccess = 0.
- Range check: address >= DEPTH is out of range.
  - mem_chipselect = 0 for out-of-range accesses.
  - oor_count increments by 1, saturating at all ones.
- Write protection: a granted in-range write with m1_debugaccess = 0 is accepted but not issued.
  - mem_write = 0 and mem_chipselect = 0.
  - wprot_count increments, saturating.
- A granted valid write drives mem_chipselect = 1 and mem_write = 1 for exactly one cycle. Writes produce no readdatavalid.
- Reads:
  - A granted read registers valid = 1, owner = winner, err = out-of-range.
  - The next cycle, the owner's readdatavalid = 1 with readdata = (err ? ERR_DATA : mem_readdata). The other master's readdatavalid = 0.
  - Latency is exactly 1 cycle. Issuing one read per cycle sustains full throughput with no bubbles.
- Back-to-back: a grant in cycle N+1 is allowed while the read from cycle N is returning.
  - mem_readdata in N+1 belongs to the N access.
  - The owner tag ensures correct routing.
- Freeze: a read granted before freeze still returns its data in the following cycle. No new grants occur until freeze = 0.
- Reset mid-operation: any pending readdatavalid is cancelled; the lost read is not replayed.
- Simultaneous out-of-range access and missing-debugaccess write: only oor_count increments.

Decomposition:
- Shared package niosii_rom_pkg holds:
  - DEPTH, AW and DW defaults;
  - ERR_DATA;
  - requester index constants REQ_IMEM = 0 and REQ_DMEM = 1.
- One natural sub-module: niosii_rr_arb2, a 2-way round-robin arbiter with last-grant register (inputs req[1:0], enable; output one-hot gnt[1:0]).
- Counters and the return path stay in the top module.

Test Plan:
- Single m0 read, address 12'h010, with mem returning 32'h1234_5678 -> m0_waitrequest = 0; m0_readdatavalid = 1 exactly one cycle later with data 32'h1234_5678; m1_readdatavalid stays 0.
- m0 and m1 read continuously for 6 cycles -> grants alternate m0, m1, m0, ... starting with m0; each master sees waitrequest = 1 on alternate cycles; every readdatavalid routes to the correct master.
- m1 write to 12'h020, byteenable 4'b0011, debugaccess = 1 -> mem_write pulses one cycle with byteenable 4'b0011. The same write with debugaccess = 0 -> mem_write = 0 and wprot_count = 1.
- m0 read at 12'hA00 (2560) -> mem_chipselect = 0; m0_readdata = 32'hDEADBEEF one cycle later; oor_count = 1. After 2^16 + 5 such reads, oor_count = 16'hFFFF.
- m1 read granted, then freeze = 1 the next cycle -> the read data still returns; m0 and m1 requests see waitrequest = 1 until freeze falls.
- reset_n asserted the cycle after an m0 read grant -> no readdatavalid; all counters = 0; after release the first tie goes to m0.
